// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared types and constants for the block dispatcher.
//   kernel_state_t : kernel-level FSM states (IDLE, INIT, DISPATCH, DONE)
//   slot_state_t   : per-core slot FSM states (FREE, RUNNING, RECLAIM)
//   BLOCK_ID_W     : width of a block index
//   TCOUNT_W       : width of the kernel thread count
//   ceil_blocks()  : ceil(n / 2**shift), used to size a launch in blocks
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INIT     = 2'd1,
    DISPATCH = 2'd2,
    DONE     = 2'd3
  } kernel_state_t;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    RUNNING = 2'd1,
    RECLAIM = 2'd2
  } slot_state_t;

  localparam int BLOCK_ID_W = 8;
  localparam int TCOUNT_W   = 8;

  // One extra bit keeps the rounding add from wrapping for n close to 255.
  function automatic logic [BLOCK_ID_W-1:0] ceil_blocks(input logic [TCOUNT_W-1:0] n,
                                                        input int unsigned shift);
    logic [TCOUNT_W:0] sum;
    sum = {1'b0, n} + ((9'd1 << shift) - 9'd1);
    return BLOCK_ID_W'(sum >> shift);
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// dispatch_slot: slot FSM and output registers for one compute core.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   kernel_init             kernel launch accepted: pulse core_reset next cycle
//   assign_valid            dispatch a block to this slot this cycle
//   assign_block_id         block index being dispatched
//   assign_thread_count     active threads in that block
//   core_done               core reports its block complete (level)
//   free                    slot can accept a block this cycle
//   retire                  block completing this cycle (RUNNING and core_done)
//   core_start/core_reset/core_block_id/core_thread_count  registered core controls
module dispatch_slot
  import dispatch_pkg::*;
#(
  parameter int TC_W = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  kernel_init,
  input  logic                  assign_valid,
  input  logic [BLOCK_ID_W-1:0] assign_block_id,
  input  logic [TC_W-1:0]       assign_thread_count,
  input  logic                  core_done,
  output logic                  free,
  output logic                  retire,
  output logic                  core_start,
  output logic                  core_reset,
  output logic [BLOCK_ID_W-1:0] core_block_id,
  output logic [TC_W-1:0]       core_thread_count
);

  slot_state_t state_r;

  // core_done is only meaningful while a block is running.
  assign free   = (state_r == FREE);
  assign retire = (state_r == RUNNING) && core_done;

  // Slot FSM plus the registered core-facing outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r           <= FREE;
      core_start        <= 1'b0;
      core_reset        <= 1'b1;
      core_block_id     <= {BLOCK_ID_W{1'b0}};
      core_thread_count <= {TC_W{1'b0}};
    end else begin
      // Single-cycle pulse on kernel launch or on reclaiming a finished core.
      core_reset <= kernel_init | retire;
      case (state_r)
        FREE: begin
          if (assign_valid) begin
            state_r           <= RUNNING;
            core_start        <= 1'b1;
            core_block_id     <= assign_block_id;
            core_thread_count <= assign_thread_count;
          end
        end
        RUNNING: begin
          if (core_done) begin
            state_r    <= RECLAIM;
            core_start <= 1'b0;
          end
        end
        // One dead cycle so the core sees its reset before new work arrives.
        RECLAIM: state_r <= FREE;
        default: begin
          state_r    <= FREE;
          core_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel launch of thread_count threads into
// blocks of THREADS_PER_BLOCK and hands them to NUM_CORES cores.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   start               kernel launch level (sampled in IDLE and DONE)
//   thread_count        total threads, latched on launch
//   core_done           per-core block-complete level
//   core_start          per-core start, held until that core's done
//   core_reset          per-core single-cycle reset pulses
//   core_block_id       block index assigned to each core
//   core_thread_count   active threads in each core's block
//   done                kernel complete
//   kernel_cycles       DISPATCH cycle count (only with BLOCK_DISPATCHER_CYCLES_EN)
// Optional feature macro: BLOCK_DISPATCHER_CYCLES_EN
module block_dispatcher
  import dispatch_pkg::*;
#(
  parameter  int NUM_CORES         = 2,
  parameter  int THREADS_PER_BLOCK = 4,
  localparam int TC_W              = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic [TCOUNT_W-1:0]                  thread_count,
  input  logic [NUM_CORES-1:0]                 core_done,
  output logic [NUM_CORES-1:0]                 core_start,
  output logic [NUM_CORES-1:0]                 core_reset,
  output logic [NUM_CORES-1:0][BLOCK_ID_W-1:0] core_block_id,
  output logic [NUM_CORES-1:0][TC_W-1:0]       core_thread_count,
  output logic                                 done
`ifdef BLOCK_DISPATCHER_CYCLES_EN
  ,
  output logic [31:0]                          kernel_cycles
`endif
);

  localparam int TPB_LOG2 = $clog2(THREADS_PER_BLOCK);

  kernel_state_t         state_r;
  logic [TCOUNT_W-1:0]   tc_r;
  logic [BLOCK_ID_W-1:0] total_r;
  logic [BLOCK_ID_W-1:0] dispatched_r;
  logic [BLOCK_ID_W-1:0] blocks_done_r;

  logic [NUM_CORES-1:0]  free_s;
  logic [NUM_CORES-1:0]  retire_s;
  logic [NUM_CORES-1:0]  pick_s;
  logic                  dispatch_ok_s;
  logic                  kernel_init_s;
  logic [BLOCK_ID_W-1:0] retire_cnt_s;
  logic [BLOCK_ID_W-1:0] last_base_s;
  logic [TCOUNT_W-1:0]   last_cnt_s;
  logic [TC_W-1:0]       assign_tc_s;

  assign kernel_init_s = (state_r == IDLE) && start;
  assign dispatch_ok_s = (state_r == DISPATCH) && (dispatched_r < total_r);

  // Lowest-indexed FREE slot wins; at most one dispatch per cycle.
  always_comb begin
    logic found;
    found  = 1'b0;
    pick_s = {NUM_CORES{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      if (dispatch_ok_s && !found && free_s[i]) begin
        pick_s[i] = 1'b1;
        found     = 1'b1;
      end else begin
        pick_s[i] = 1'b0;
      end
    end
  end

  // Thread count for the block being dispatched: the last block gets the remainder.
  always_comb begin
    last_base_s = (total_r - 8'd1) << TPB_LOG2;
    last_cnt_s  = tc_r - last_base_s;
    if (dispatched_r == (total_r - 8'd1)) begin
      assign_tc_s = TC_W'(last_cnt_s);
    end else begin
      assign_tc_s = TC_W'(THREADS_PER_BLOCK);
    end
  end

  // Several cores may finish in the same cycle; each completion counts.
  always_comb begin
    retire_cnt_s = 8'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      retire_cnt_s = retire_cnt_s + {7'd0, retire_s[i]};
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(
      .TC_W(TC_W)
    ) u_slot (
      .clk                (clk),
      .reset_n            (reset_n),
      .kernel_init        (kernel_init_s),
      .assign_valid       (pick_s[g]),
      .assign_block_id    (dispatched_r),
      .assign_thread_count(assign_tc_s),
      .core_done          (core_done[g]),
      .free               (free_s[g]),
      .retire             (retire_s[g]),
      .core_start         (core_start[g]),
      .core_reset         (core_reset[g]),
      .core_block_id      (core_block_id[g]),
      .core_thread_count  (core_thread_count[g])
    );
  end

  // Kernel FSM, block counters and the done flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      tc_r          <= 8'd0;
      total_r       <= 8'd0;
      dispatched_r  <= 8'd0;
      blocks_done_r <= 8'd0;
      done          <= 1'b0;
`ifdef BLOCK_DISPATCHER_CYCLES_EN
      kernel_cycles <= 32'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tc_r    <= thread_count;
            total_r <= ceil_blocks(thread_count, TPB_LOG2);
            state_r <= INIT;
          end
        end
        INIT: begin
          dispatched_r  <= 8'd0;
          blocks_done_r <= 8'd0;
`ifdef BLOCK_DISPATCHER_CYCLES_EN
          kernel_cycles <= 32'd0;
`endif
          state_r       <= DISPATCH;
        end
        DISPATCH: begin
          if (|pick_s) begin
            dispatched_r <= dispatched_r + 8'd1;
          end
          blocks_done_r <= blocks_done_r + retire_cnt_s;
          // Zero-block launches fall through here on the first DISPATCH cycle.
          if (blocks_done_r == total_r) begin
            done    <= 1'b1;
            state_r <= DONE;
          end
`ifdef BLOCK_DISPATCHER_CYCLES_EN
          if (kernel_cycles != 32'hFFFF_FFFF) begin
            kernel_cycles <= kernel_cycles + 32'd1;
          end
`endif
        end
        DONE: begin
          if (!start) begin
            done    <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: scoreboard bench for block_dispatcher (NUM_CORES=2, TPB=4).
// The launch task pushes the expected block sequence into a queue; a monitor
// process models the cores, pops and compares on every core_start rise, and
// checks reclaim pulses and the done edge.
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCW = $clog2(TPB) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] thread_count = 8'd0;
  logic [NC-1:0] core_done = '0;
  logic [NC-1:0] core_start;
  logic [NC-1:0] core_reset;
  logic [NC-1:0][7:0] core_block_id;
  logic [NC-1:0][TCW-1:0] core_thread_count;
  logic done;
`ifdef BLOCK_DISPATCHER_CYCLES_EN
  logic [31:0] kernel_cycles;
`endif

  block_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
`ifdef BLOCK_DISPATCHER_CYCLES_EN
    .kernel_cycles(kernel_cycles),
`endif
    .clk(clk), .reset_n(reset_n), .start(start), .thread_count(thread_count),
    .core_done(core_done), .core_start(core_start), .core_reset(core_reset),
    .core_block_id(core_block_id), .core_thread_count(core_thread_count), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int cnt; } blk_t;
  blk_t exp_q[$];
  int checks = 0, failures = 0;
  int launch_edge, total_exp, completions, last_comp;
  int blk_core[256], blk_edge[256];
  int lat_fix[NC];
  bit rand_hold = 1'b0;
  bit in_reset = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core model + monitor: runs on the falling edge, away from the active edge.
  initial begin
    logic [NC-1:0] prev_start;
    logic prev_done;
    int comp_edge[NC], sched[NC];
    bit xhold[NC];
    int rises, lat, exp_edge;
    blk_t e;
    prev_start = '0;
    prev_done = 1'b0;
    for (int i = 0; i < NC; i++) begin comp_edge[i] = -100; sched[i] = -1; xhold[i] = 1'b0; end
    forever begin
      @(negedge clk);
      if (in_reset) begin
        core_done = '0;
        for (int i = 0; i < NC; i++) begin comp_edge[i] = -100; sched[i] = -1; end
      end else begin
        rises = 0;
        for (int i = 0; i < NC; i++) begin
          if (core_start[i] && !prev_start[i]) begin
            rises++;
            check("dispatch_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("block_id", core_block_id[i], e.id);
              check("thread_count", core_thread_count[i], e.cnt);
              blk_core[e.id] = i;
              blk_edge[e.id] = cyc;
            end
            check("reclaim_gap", cyc >= comp_edge[i] + 2, 1);
            for (int j = 0; j < i; j++)
              check("lowest_free_slot", !prev_start[j] && (comp_edge[j] <= cyc - 2), 0);
            lat = (lat_fix[i] > 0) ? lat_fix[i] : int'($urandom_range(2, 9));
            sched[i] = cyc + lat - 1;
          end
        end
        if (rises > 0) check("one_dispatch_per_cycle", rises, 1);
        for (int i = 0; i < NC; i++) begin
          if (cyc == comp_edge[i]) begin
            check("reclaim_reset", core_reset[i], 1);
            check("reclaim_start_low", core_start[i], 0);
            if (!xhold[i]) core_done[i] = 1'b0;
          end
          if (cyc == comp_edge[i] + 1) begin
            check("reclaim_reset_pulse", core_reset[i], 0);
            core_done[i] = 1'b0;
          end
          if (cyc == sched[i]) begin
            core_done[i] = 1'b1;
            comp_edge[i] = cyc + 1;
            completions++;
            last_comp = cyc + 1;
            xhold[i] = rand_hold ? 1'($urandom_range(0, 1)) : 1'b0;
            sched[i] = -1;
          end
        end
        if (done && !prev_done) begin
          exp_edge = (total_exp == 0) ? launch_edge + 2 : last_comp + 1;
          check("done_edge", cyc, exp_edge);
          check("done_blocks_left", exp_q.size(), 0);
          check("done_completions", completions, total_exp);
        end
      end
      prev_start = core_start;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    reset_n = 1'b0;
    start = 1'b0;
    tick();
    check("rst_core_start", core_start, 0);
    check("rst_core_reset", core_reset, {NC{1'b1}});
    check("rst_block_id", core_block_id, 0);
    check("rst_thread_count", core_thread_count, 0);
    check("rst_done", done, 0);
`ifdef BLOCK_DISPATCHER_CYCLES_EN
    check("rst_kernel_cycles", kernel_cycles, 0);
`endif
    exp_q.delete();
    reset_n = 1'b1;
    in_reset = 1'b0;
    tick();
  endtask

  task automatic do_launch(input int tc);
    exp_q.delete();
    total_exp = (tc + TPB - 1) / TPB;
    for (int b = 0; b < total_exp; b++) begin
      blk_t e;
      e.id = b;
      e.cnt = (tc - b * TPB < TPB) ? tc - b * TPB : TPB;
      exp_q.push_back(e);
    end
    for (int b = 0; b < 256; b++) begin blk_core[b] = -1; blk_edge[b] = -1; end
    completions = 0;
    last_comp = -1;
    thread_count = 8'(tc);
    start = 1'b1;
    launch_edge = cyc + 1;
    tick();
    check("init_core_reset", core_reset, {NC{1'b1}});
    check("init_core_start", core_start, 0);
    thread_count = 8'($urandom);  // must be ignored after launch
    tick();
    check("init_reset_pulse_end", core_reset, 0);
  endtask

  task automatic finish_kernel();
    int n = 0;
    int kc_exp;
    while (!done && n < 3000) begin tick(); n++; end
    check("done_seen", done, 1);
    if (!done) begin
      do_reset();
      return;
    end
    kc_exp = cyc - launch_edge - 1;
    if (total_exp > 0) begin
      check("first_dispatch_edge", blk_edge[0], launch_edge + 2);
      check("first_dispatch_core", blk_core[0], 0);
    end
    if (total_exp > 1) begin
      check("second_dispatch_edge", blk_edge[1], launch_edge + 3);
      check("second_dispatch_core", blk_core[1], 1);
    end
`ifdef BLOCK_DISPATCHER_CYCLES_EN
    check("kernel_cycles_done", kernel_cycles, kc_exp);
`endif
    tick();
    tick();
    check("done_hold", done, 1);
    start = 1'b0;
    tick();
    check("done_clear", done, 0);
`ifdef BLOCK_DISPATCHER_CYCLES_EN
    check("kernel_cycles_hold", kernel_cycles, kc_exp);
`endif
    tick();
  endtask

  initial begin
    int tcs[4];
    lat_fix[0] = 0;
    lat_fix[1] = 0;
    tick();
    tick();
    check("reset_core_start", core_start, 0);
    check("reset_core_reset", core_reset, {NC{1'b1}});
    check("reset_block_id", core_block_id, 0);
    check("reset_thread_count", core_thread_count, 0);
    check("reset_done", done, 0);
`ifdef BLOCK_DISPATCHER_CYCLES_EN
    check("reset_kernel_cycles", kernel_cycles, 0);
`endif
    reset_n = 1'b1;
    in_reset = 1'b0;
    tick();

    // Two full blocks, each core done 5 cycles after start.
    lat_fix[0] = 5; lat_fix[1] = 5;
    do_launch(8);
    finish_kernel();

    // Three blocks; core 1 finishes first and must receive block 2.
    lat_fix[0] = 8; lat_fix[1] = 3;
    do_launch(10);
    finish_kernel();
    check("block2_to_first_reclaimed", blk_core[2], 1);

    // Empty launch.
    do_launch(0);
    finish_kernel();

    // Both cores finish on the same edge with blocks 2,3 outstanding.
    lat_fix[0] = 6; lat_fix[1] = 5;
    do_launch(16);
    finish_kernel();
    check("dual_block2_core", blk_core[2], 0);
    check("dual_block2_edge", blk_edge[2], launch_edge + 10);
    check("dual_block3_core", blk_core[3], 1);
    check("dual_block3_edge", blk_edge[3], launch_edge + 11);

    // Reset mid-DISPATCH, then a fresh launch restarts from block 0.
    lat_fix[0] = 0; lat_fix[1] = 0;
    rand_hold = 1'b1;
    do_launch(40);
    for (int k = 0; k < 6; k++) tick();
    do_reset();
    lat_fix[0] = 5; lat_fix[1] = 5;
    rand_hold = 1'b0;
    do_launch(8);
    finish_kernel();

    // Single block, done raised 6 cycles after dispatch.
    lat_fix[0] = 7; lat_fix[1] = 7;
    do_launch(3);
    finish_kernel();
`ifdef BLOCK_DISPATCHER_CYCLES_EN
    check("kernel_cycles_single", kernel_cycles, 9);
`endif

    // Randomized launches including boundary sizes.
    lat_fix[0] = 0; lat_fix[1] = 0;
    rand_hold = 1'b1;
    tcs[0] = 255; tcs[1] = 1; tcs[2] = 4; tcs[3] = 5;
    for (int r = 0; r < 12; r++) begin
      do_launch((r < 4) ? tcs[r] : int'($urandom_range(0, 80)));
      finish_kernel();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
